whiten_stream: RTL and testbench

WHITEN_STREAM -- requirements
Module: whiten_stream

---
 rtl/whiten_stream_pkg.sv | 9 +
 rtl/whiten_stream_lfsr.sv | 32 +++
 rtl/whiten_stream.sv | 101 ++++++++++
 tb/tb_whiten_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/whiten_stream_pkg.sv
// whiten_stream_pkg: BLE whitening defaults and stream FSM encoding
package whiten_stream_pkg;
  localparam int BLE_LFSR_WIDTH = 7;
  localparam logic [6:0] BLE_LFSR_TAPS = 7'b0010000;
  localparam int BLE_SKIP_1M = 40;
  localparam int BLE_SKIP_2M = 48;
  localparam int BLE_MAX_PKT_BITS = 2120;
  typedef enum logic [1:0] {IDLE, PASS, WHITEN} state_t;
endpackage

// File: rtl/whiten_stream_lfsr.sv
// whiten_lfsr: Galois whitening LFSR with channel seed load and per-bit step
module whiten_lfsr #(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = 7'b0010000,
  parameter int CH_W = 6
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CH_W-1:0] ch,
  input  logic            step,
  output logic            out_bit
);
  logic [WIDTH-1:0] lfsr_q, lfsr_d, seed, nxt;
  assign seed[0] = 1'b1;
  for (genvar k = 1; k < WIDTH; k++) begin : g_seed
    if (k <= CH_W) begin : g_ch
      assign seed[k] = ch[CH_W-k];
    end else begin : g_zero
      assign seed[k] = 1'b0;
    end
  end
  always_comb begin
    nxt = {lfsr_q[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{lfsr_q[WIDTH-1]}});
    nxt[0] = lfsr_q[WIDTH-1];
    lfsr_d = load ? seed : step ? nxt : lfsr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= WIDTH'(1);
    else lfsr_q <= lfsr_d;
  assign out_bit = lfsr_q[WIDTH-1];
endmodule

// File: rtl/whiten_stream.sv
// whiten_stream: serial packet whitener with unwhitened header skip, 1-cycle latency
module whiten_stream
  import whiten_stream_pkg::*;
#(
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int LFSR_WIDTH = BLE_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = BLE_LFSR_TAPS,
  parameter int SKIP_WIDTH = 7,
  parameter int MAX_PKT_BITS = BLE_MAX_PKT_BITS
)(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                channel_number_load,
  input  logic [SKIP_WIDTH-1:0]               skip_len,
  input  logic                                whiten_en,
  input  logic                                data_in,
  input  logic                                data_in_valid,
  input  logic                                data_in_valid_last,
  output logic                                data_out,
  output logic                                data_out_valid,
  output logic                                data_out_valid_last,
  output logic                                err_overflow,
  output logic                                cfg_err
);
  localparam int CW = $clog2(MAX_PKT_BITS + 1);
  localparam int XW = CW > SKIP_WIDTH ? CW : SKIP_WIDTH;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic [SKIP_WIDTH-1:0] skip_q, skip_d, cur_skip;
  logic en_q, en_d, cur_en, idle, whiten, ovf;
  logic dout_q, dout_d, vout_q, vout_d, lout_q, lout_d, ovf_q, cfg_q, cfg_d;
  logic lfsr_bit, lfsr_load;
  always_comb begin
    idle = state_q == IDLE;
    cur_skip = idle ? skip_len : skip_q;
    cur_en = idle ? whiten_en : en_q;
    count_inc = idle ? CW'(1) : (count_q == CW'(MAX_PKT_BITS)) ? count_q : count_q + CW'(1);
    whiten = data_in_valid && (state_q == WHITEN || (idle && whiten_en && skip_len == '0));
    // count_inc includes the current bit, so the overrun fires on the MAX_PKT_BITS-th bit
    ovf = data_in_valid && !data_in_valid_last && count_inc == CW'(MAX_PKT_BITS);
    lfsr_load = channel_number_load && idle && !data_in_valid;
    cfg_d = channel_number_load && !lfsr_load;
    state_d = state_q;
    count_d = count_q;
    skip_d = skip_q;
    en_d = en_q;
    if (data_in_valid) begin
      count_d = count_inc;
      skip_d = cur_skip;
      en_d = cur_en;
      state_d = (cur_en && XW'(count_inc) >= XW'(cur_skip)) ? WHITEN : PASS;
      if (data_in_valid_last || ovf) begin
        state_d = IDLE;
        count_d = '0;
      end
    end
    dout_d = data_in_valid & (data_in ^ (whiten & lfsr_bit));
    vout_d = data_in_valid;
    lout_d = data_in_valid & data_in_valid_last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      skip_q <= '0;
      en_q <= 1'b0;
      dout_q <= 1'b0;
      vout_q <= 1'b0;
      lout_q <= 1'b0;
      ovf_q <= 1'b0;
      cfg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      skip_q <= skip_d;
      en_q <= en_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      lout_q <= lout_d;
      ovf_q <= ovf;
      cfg_q <= cfg_d;
    end
  whiten_lfsr #(
    .WIDTH(LFSR_WIDTH),
    .TAPS(LFSR_TAPS),
    .CH_W(CHANNEL_NUMBER_BIT_WIDTH)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .load(lfsr_load),
    .ch(channel_number),
    .step(whiten),
    .out_bit(lfsr_bit)
  );
  assign data_out = dout_q;
  assign data_out_valid = vout_q;
  assign data_out_valid_last = lout_q;
  assign err_overflow = ovf_q;
  assign cfg_err = cfg_q;
endmodule

// File: tb/tb_whiten_stream.sv
// tb_whiten_stream: vector table plus scoreboarded packet sequences for whiten_stream
module tb_whiten_stream;
  localparam int MAX = 64;
  localparam logic [6:0] TAPS = 7'b0010000;
  logic clk, rst;
  logic [5:0] channel_number;
  logic channel_number_load, whiten_en, data_in, data_in_valid, data_in_valid_last;
  logic [6:0] skip_len;
  logic data_out, data_out_valid, data_out_valid_last, err_overflow, cfg_err;
  typedef struct {int cyc; logic d; logic last; logic ovf;} exp_t;
  typedef struct {logic ld; logic [5:0] ch; logic v; logic d; logic last; logic [6:0] skip; logic en; logic ed;} vec_t;
  exp_t sb[$];
  vec_t tab[11];
  int checks = 0, errors = 0, cyc = 0, cfg_at = -10, m_idx = 0;
  logic [6:0] m_lfsr = 7'b1, m_skip = '0;
  logic m_en = 1'b0;

  whiten_stream #(
    .CHANNEL_NUMBER_BIT_WIDTH(6), .LFSR_WIDTH(7), .LFSR_TAPS(TAPS),
    .SKIP_WIDTH(7), .MAX_PKT_BITS(MAX)
  ) dut (
    .clk(clk), .rst(rst), .channel_number(channel_number),
    .channel_number_load(channel_number_load), .skip_len(skip_len),
    .whiten_en(whiten_en), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_valid_last(data_in_valid_last), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_valid_last(data_out_valid_last),
    .err_overflow(err_overflow), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] seed(input logic [5:0] ch);
    logic [6:0] s;
    s[0] = 1'b1;
    for (int k = 1; k < 7; k++) s[k] = ch[6-k];
    return s;
  endfunction

  function automatic logic [6:0] step(input logic [6:0] q);
    logic [6:0] n;
    n[0] = q[6];
    for (int k = 1; k < 7; k++) n[k] = q[k-1] ^ (TAPS[k] & q[6]);
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {27'd0, data_out, data_out_valid, data_out_valid_last, err_overflow, cfg_err}, 0);
      sb.delete();
    end else begin
      logic exp_v;
      exp_t e;
      exp_v = sb.size() > 0 && sb[0].cyc == cyc - 1;
      chk("out_valid", {31'd0, data_out_valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = sb.pop_front();
        chk("out_data", {31'd0, data_out}, {31'd0, e.d});
        chk("out_last", {31'd0, data_out_valid_last}, {31'd0, e.last});
        chk("overflow", {31'd0, err_overflow}, {31'd0, e.ovf});
      end else begin
        chk("idle_outputs", {29'd0, data_out, data_out_valid_last, err_overflow}, 0);
      end
      chk("cfg_err", {31'd0, cfg_err}, {31'd0, cfg_at == cyc - 1});
    end
  end

  // Reference model: bit idx of a packet is whitened iff en && idx > skip
  task automatic drive(input logic ld, input logic [5:0] ch, input logic v, input logic d,
                       input logic last, input logic [6:0] skip, input logic en,
                       input logic use_e, input logic ed);
    logic w, ex, of;
    if (ld) begin
      if (m_idx == 0 && !v) m_lfsr = seed(ch);
      else cfg_at = cyc;
    end
    if (v) begin
      if (m_idx == 0) begin
        m_skip = skip;
        m_en = en;
      end
      m_idx++;
      w = m_en && m_idx > int'(m_skip);
      ex = use_e ? ed : d ^ (w & m_lfsr[6]);
      if (w) m_lfsr = step(m_lfsr);
      of = !last && m_idx == MAX;
      sb.push_back('{cyc, ex, last, of});
      if (last || of) m_idx = 0;
    end
    channel_number_load = ld;
    channel_number = ch;
    data_in_valid = v;
    data_in = d;
    data_in_valid_last = last;
    skip_len = skip;
    whiten_en = en;
    @(posedge clk);
    #1;
    channel_number_load = 1'b0;
    data_in_valid = 1'b0;
    data_in = 1'b0;
    data_in_valid_last = 1'b0;
  endtask

  task automatic load(input logic [5:0] ch);
    drive(1'b1, ch, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic packet(input int n, input logic [6:0] skip, input logic en, input logic rnd,
                        input int max_gap, input logic with_last);
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      drive(1'b0, 6'd0, 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b0, with_last && i == n,
            skip, en, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    channel_number = '0;
    channel_number_load = 1'b0;
    skip_len = '0;
    whiten_en = 1'b0;
    data_in = 1'b0;
    data_in_valid = 1'b0;
    data_in_valid_last = 1'b0;
    tab[0]  = '{1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0};
    tab[1]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0};
    tab[2]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd0, 1'b1, 1'b1};
    tab[3]  = '{1'b1, 6'd1, 1'b1, 1'b0, 1'b1, 7'd1, 1'b1, 1'b0};
    tab[4]  = '{1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0};
    tab[5]  = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0};
    tab[6]  = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b1};
    tab[7]  = '{1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0};
    tab[8]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd1, 1'b1, 1'b0};
    tab[9]  = '{1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1};
    tab[10] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++)
      drive(tab[i].ld, tab[i].ch, tab[i].v, tab[i].d, tab[i].last, tab[i].skip, tab[i].en, 1'b1, tab[i].ed);
    load(6'd37);
    packet(60, 7'd40, 1'b1, 1'b0, 0, 1'b1);
    load(6'd37);
    packet(60, 7'd40, 1'b0, 1'b1, 0, 1'b1);
    packet(12, 7'd0, 1'b1, 1'b1, 0, 1'b1);
    load(6'd0);
    packet(60, 7'd48, 1'b1, 1'b1, 3, 1'b1);
    load(6'd2);
    packet(70, 7'd40, 1'b1, 1'b1, 0, 1'b0);
    load(6'd5);
    packet(2, 7'd40, 1'b1, 1'b1, 0, 1'b0);
    #1 rst = 1'b1;
    #1 chk("async_reset", {27'd0, data_out, data_out_valid, data_out_valid_last, err_overflow, cfg_err}, 0);
    sb.delete();
    m_idx = 0;
    m_lfsr = 7'b1;
    cfg_at = -10;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    packet(12, 7'd0, 1'b1, 1'b1, 0, 1'b1);
    load(6'd9);
    packet(20, 7'd1, 1'b1, 1'b1, 2, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
